// File: rtl/imem_load_arbiter.sv
// imem_load_arbiter
//   Owns the instruction-memory port. In run mode the fetch word address is
//   passed straight through. In load mode the CPU is frozen, loader bytes are
//   packed little-endian into 32-bit words and written to consecutive
//   addresses from 0. After the load, the CPU is held in reset for HOLD_CYCLES
//   cycles before returning to run mode.
//
// Ports
//   i_clock        system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_load_req     request load mode (sampled only in RUN)
//   i_byte_valid   loader byte present
//   i_byte_data    loader byte
//   o_byte_ready   byte accepted this cycle when i_byte_valid is also 1
//   i_load_end     loader stream finished (sampled only in LOAD)
//   i_fetch_addr   word address from the fetch stage
//   o_imem_addr    instruction-memory address
//   o_imem_wdata   instruction-memory write data
//   o_imem_we      instruction-memory write enable
//   o_cpu_hold     freezes PC update and register writes
//   o_cpu_rst      active-high CPU reset after a load
//   o_load_busy    1 in every state except RUN
//   o_load_count   words written by the current or most recent load
//
// state     | meaning
// S_RUN     | fetch owns imem, loader ignored
// S_LOAD    | CPU frozen, collecting loader bytes into the word register
// S_WRITE   | one-cycle write of the packed word at wr_ptr
// S_RELEASE | CPU held in reset for HOLD_CYCLES cycles
module imem_load_arbiter #(
  parameter int ADDR_W      = 14,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              i_clock,
  input  logic              i_rst_n,
  input  logic              i_load_req,
  input  logic              i_byte_valid,
  input  logic [7:0]        i_byte_data,
  output logic              o_byte_ready,
  input  logic              i_load_end,
  input  logic [ADDR_W-1:0] i_fetch_addr,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic              o_imem_we,
  output logic              o_cpu_hold,
  output logic              o_cpu_rst,
  output logic              o_load_busy,
  output logic [ADDR_W:0]   o_load_count
);

  typedef enum logic [1:0] {S_RUN, S_LOAD, S_WRITE, S_RELEASE} state_t;

  localparam logic [7:0]        HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [ADDR_W-1:0] PTR_MAX   = '1;
  localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_t              r_state;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [2:0]          r_byte_cnt;
  logic [31:0]         r_word;
  logic                r_end_flag;
  logic [ADDR_W:0]     r_load_count;
  logic [7:0]          r_hold_cnt;

  logic                w_xfer;
  logic [2:0]          w_cnt_next;
  logic [31:0]         w_word_next;

  assign w_xfer     = (r_state == S_LOAD) && i_byte_valid;
  assign w_cnt_next = r_byte_cnt + {2'b00, w_xfer};

  // In LOAD r_byte_cnt is always 0..3, so its low two bits select the lane.
  always_comb begin
    w_word_next = r_word;
    if (w_xfer) w_word_next[{r_byte_cnt[1:0], 3'b000} +: 8] = i_byte_data;
  end

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_RUN;
      r_wr_ptr     <= '0;
      r_byte_cnt   <= '0;
      r_word       <= '0;
      r_end_flag   <= 1'b0;
      r_load_count <= '0;
      r_hold_cnt   <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (i_load_req) begin
            r_state      <= S_LOAD;
            r_wr_ptr     <= '0;
            r_byte_cnt   <= '0;
            r_end_flag   <= 1'b0;
            r_word       <= '0;
            r_load_count <= '0;
          end
        end
        S_LOAD: begin
          r_byte_cnt <= w_cnt_next;
          r_word     <= w_word_next;
          if (i_load_end) r_end_flag <= 1'b1;
          // A byte arriving with load_end is packed before the end is acted on.
          if (w_cnt_next == 3'd4) begin
            r_state <= S_WRITE;
          end else if (i_load_end) begin
            if (w_cnt_next != 3'd0) begin
              r_state <= S_WRITE;
            end else begin
              r_state    <= S_RELEASE;
              r_hold_cnt <= HOLD_LAST;
            end
          end
        end
        S_WRITE: begin
          r_load_count <= r_load_count + CNT_ONE;
          r_byte_cnt   <= '0;
          r_word       <= '0;
          // Pointer saturates at the top address; the load ends there anyway.
          if (r_wr_ptr != PTR_MAX) r_wr_ptr <= r_wr_ptr + PTR_ONE;
          if (r_end_flag || (r_wr_ptr == PTR_MAX)) begin
            r_state    <= S_RELEASE;
            r_hold_cnt <= HOLD_LAST;
          end else begin
            r_state <= S_LOAD;
          end
        end
        S_RELEASE: begin
          if (r_hold_cnt == 8'd0) r_state <= S_RUN;
          else                    r_hold_cnt <= r_hold_cnt - 8'd1;
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  assign o_imem_addr  = (r_state == S_RUN) ? i_fetch_addr : r_wr_ptr;
  assign o_imem_wdata = (r_state == S_WRITE) ? r_word : 32'd0;
  assign o_imem_we    = (r_state == S_WRITE);
  assign o_byte_ready = (r_state == S_LOAD);
  assign o_cpu_hold   = (r_state != S_RUN);
  assign o_cpu_rst    = (r_state == S_RELEASE);
  assign o_load_busy  = (r_state != S_RUN);
  assign o_load_count = r_load_count;

endmodule

// File: tb/tb_imem_load_arbiter.sv
module tb_imem_load_arbiter;

  localparam int AW   = 2;
  localparam int HOLD = 4;
  localparam int CAP_BYTES = 4 * (1 << AW);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_req = 1'b0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = 8'h00;
  logic          load_end = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic          byte_ready;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          imem_we;
  logic          cpu_hold;
  logic          cpu_rst;
  logic          load_busy;
  logic [AW:0]   load_count;

  imem_load_arbiter #(.ADDR_W(AW), .HOLD_CYCLES(HOLD)) dut (
    .i_clock      (clk),
    .i_rst_n      (rst_n),
    .i_load_req   (load_req),
    .i_byte_valid (byte_valid),
    .i_byte_data  (byte_data),
    .o_byte_ready (byte_ready),
    .i_load_end   (load_end),
    .i_fetch_addr (fetch_addr),
    .o_imem_addr  (imem_addr),
    .o_imem_wdata (imem_wdata),
    .o_imem_we    (imem_we),
    .o_cpu_hold   (cpu_hold),
    .o_cpu_rst    (cpu_rst),
    .o_load_busy  (load_busy),
    .o_load_count (load_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Write observer: captures every imem write and checks write-side invariants.
  logic [AW-1:0] wr_addr_q[$];
  logic [31:0]   wr_data_q[$];
  int            rst_cycles = 0;
  logic          prev_we = 1'b0;

  always @(negedge clk) begin
    if (imem_we) begin
      chk("we_pair", prev_we, 0);
      chk("we_in_rst", cpu_rst, 0);
      chk("we_hold", cpu_hold, 1);
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
    end
    if (cpu_rst) rst_cycles++;
    prev_we = imem_we;
  end

  logic [7:0] stim [32];

  task automatic tick();
    @(negedge clk);
  endtask

  // Runs one load of stim[0..n-1]. end_same puts load_end on the last byte,
  // do_end sends a separate load_end afterwards, pulse pokes load_req in RELEASE.
  task automatic do_load(input int n, input bit end_same, input bit do_end, input bit pulse);
    int          acc;
    int          waitc;
    int          exp_acc;
    int          exp_words;
    logic [31:0] exp_w;
    bit          prev_rst_l;
    bit          pulsed;
    acc = 0;
    pulsed = 0;
    prev_rst_l = 0;
    wr_addr_q.delete();
    wr_data_q.delete();
    rst_cycles = 0;
    load_req = 1'b1;
    tick();
    chk("hold_latency", cpu_hold, 1);
    chk("busy_on", load_busy, 1);
    load_req = 1'b0;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      byte_valid = 1'b1;
      byte_data  = stim[i];
      if (end_same && i == n - 1) load_end = 1'b1;
      waitc = 0;
      while (!byte_ready && waitc < 20) begin
        tick();
        waitc++;
      end
      if (!byte_ready) begin
        byte_valid = 1'b0;
        load_end   = 1'b0;
        break;
      end
      acc++;
      tick();
      byte_valid = 1'b0;
      load_end   = 1'b0;
    end
    if (do_end && !end_same) begin
      waitc = 0;
      while (!byte_ready && waitc < 20) begin
        tick();
        waitc++;
      end
      chk("end_ready", byte_ready, 1);
      load_end = 1'b1;
      tick();
      load_end = 1'b0;
    end
    waitc = 0;
    while (cpu_hold && waitc < 60) begin
      if (pulse && cpu_rst && !pulsed) begin
        load_req = 1'b1;
        pulsed = 1;
      end
      prev_rst_l = cpu_rst;
      tick();
      load_req = 1'b0;
      waitc++;
    end
    chk("released", cpu_hold, 0);
    if (waitc > 0) chk("rst_then_run", prev_rst_l, 1);
    chk("rst_cycles", rst_cycles, HOLD);
    chk("busy_off", load_busy, 0);
    chk("cpu_rst_off", cpu_rst, 0);
    // Reference: bytes beyond memory capacity are refused, words are packed
    // little-endian with zero fill, one write per started word.
    exp_acc   = (n > CAP_BYTES) ? CAP_BYTES : n;
    exp_words = (exp_acc + 3) / 4;
    chk("accepted", acc, exp_acc);
    chk("load_count", load_count, exp_words);
    chk("n_writes", wr_addr_q.size(), exp_words);
    for (int w = 0; w < exp_words && w < wr_addr_q.size(); w++) begin
      exp_w = 32'd0;
      for (int j = 0; j < 4; j++)
        if (4 * w + j < exp_acc) exp_w = exp_w | (32'(stim[4 * w + j]) << (8 * j));
      chk("wr_addr", wr_addr_q[w], w);
      chk("wr_data", wr_data_q[w], exp_w);
    end
    repeat (2) tick();
    chk("stay_run", load_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog tests=%0d", n_tests);
    $fatal(1, "timeout");
  end

  initial begin
    int  n;
    bit  es;
    bit  de;
    // Reset values
    #3;
    chk("rst_we", imem_we, 0);
    chk("rst_hold", cpu_hold, 0);
    chk("rst_cpu_rst", cpu_rst, 0);
    chk("rst_ready", byte_ready, 0);
    chk("rst_busy", load_busy, 0);
    chk("rst_count", load_count, 0);
    chk("rst_wdata", imem_wdata, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Run-mode pass-through
    for (int i = 0; i < 8; i++) begin
      fetch_addr = AW'($urandom);
      #1;
      chk("pass", imem_addr, fetch_addr);
      tick();
    end

    // Reset mid-stream after two bytes
    wr_addr_q.delete();
    wr_data_q.delete();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      byte_valid = 1'b1;
      byte_data  = 8'h5A + 8'(i);
      tick();
    end
    byte_valid = 1'b1;
    byte_data  = 8'hC3;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_we", imem_we, 0);
    chk("abort_hold", cpu_hold, 0);
    chk("abort_busy", load_busy, 0);
    chk("abort_count", load_count, 0);
    chk("abort_ready", byte_ready, 0);
    chk("abort_rst", cpu_rst, 0);
    chk("abort_wdata", imem_wdata, 0);
    chk("abort_addr", imem_addr, fetch_addr);
    byte_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("abort_no_write", wr_addr_q.size(), 0);
    chk("abort_idle", load_busy, 0);

    // Two-word load, load_req poked during RELEASE
    stim[0] = 8'h13; stim[1] = 8'h00; stim[2] = 8'h08; stim[3] = 8'h20;
    stim[4] = 8'h01; stim[5] = 8'h02; stim[6] = 8'h03; stim[7] = 8'h04;
    do_load(8, 1'b0, 1'b1, 1'b1);

    // Partial word
    stim[0] = 8'hAA; stim[1] = 8'hBB;
    do_load(2, 1'b0, 1'b1, 1'b0);

    // Fourth byte together with load_end
    stim[0] = 8'h77; stim[1] = 8'h66; stim[2] = 8'h55; stim[3] = 8'h11;
    do_load(4, 1'b1, 1'b0, 1'b0);

    // Overflow: 20 bytes into a 4-word memory
    for (int i = 0; i < 20; i++) stim[i] = 8'($urandom);
    do_load(20, 1'b0, 1'b0, 1'b0);

    // Empty load
    do_load(0, 1'b0, 1'b1, 1'b0);

    // Randomized loads
    for (int t = 0; t < 12; t++) begin
      n = $urandom_range(0, 19);
      for (int i = 0; i < n; i++) stim[i] = 8'($urandom);
      if (n >= CAP_BYTES) begin
        es = (n == CAP_BYTES) && ($urandom_range(0, 1) == 1);
        de = 1'b0;
      end else begin
        es = (n > 0) && ($urandom_range(0, 1) == 1);
        de = !es;
      end
      do_load(n, es, de, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
